// File: rtl/id_ex_pipe_pkg.sv
// rtl/id_ex_pipe_pkg.sv - shared widths and state encoding for the ID->EX pipeline stage
package id_ex_pipe_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int CTRL_W_DEF = 4;

    typedef enum logic [1:0] {
        ID_EX_EMPTY = 2'd0,
        ID_EX_HALF  = 2'd1,
        ID_EX_FULL  = 2'd2
    } id_ex_state_e;

    // Packed entry layout: {pc, op1, op2, rs1, rs2, rd, we, alu_ctrl, sub, sign}
    function automatic int entry_width(input int dw, input int aw, input int cw);
        return 3 * dw + 3 * aw + cw + 3;
    endfunction

endpackage

// File: rtl/id_ex_pipe_fwd.sv
// rtl/id_ex_pipe_fwd.sv - operand patch from the writeback port (x0 never forwards)
module opd_fwd
    import id_ex_pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] rs_i,
    input  logic [DATA_W-1:0] op_i,
    input  logic              wb_we_i,
    input  logic [ADDR_W-1:0] wb_addr_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic [DATA_W-1:0] op_o
);

    assign op_o = (wb_we_i && (wb_addr_i != '0) && (wb_addr_i == rs_i)) ? wb_data_i : op_i;

endmodule

// File: rtl/id_ex_pipe.sv
// rtl/id_ex_pipe.sv - ID->EX stage with two-entry skid buffer; FORWARD_EN adds writeback forwarding
module id_ex_pipe
    import id_ex_pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_op1,
    input  logic [DATA_W-1:0] in_op2,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              in_we,
    input  logic [CTRL_W-1:0] in_alu_ctrl,
    input  logic              in_sub,
    input  logic              in_sign,
    input  logic              out_ready,
`ifdef FORWARD_EN
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
`endif
    output logic              out_valid,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_op1,
    output logic [DATA_W-1:0] out_op2,
    output logic [ADDR_W-1:0] out_rs1,
    output logic [ADDR_W-1:0] out_rs2,
    output logic [ADDR_W-1:0] out_rd,
    output logic              out_we,
    output logic [CTRL_W-1:0] out_alu_ctrl,
    output logic              out_sub,
    output logic              out_sign
);

    localparam int ENTRY_W = entry_width(DATA_W, ADDR_W, CTRL_W);
    localparam int OFF_RS1 = 3 + CTRL_W + 2 * ADDR_W;
    localparam int OFF_OP2 = OFF_RS1 + ADDR_W;
    localparam int OFF_OP1 = OFF_OP2 + DATA_W;

    id_ex_state_e       state_q;
    logic [ENTRY_W-1:0] main_q;
    logic [ENTRY_W-1:0] skid_q;
    logic               in_ready_q;
    logic               out_valid_q;

    // Index 0 = entry being captured, 1 = main, 2 = skid
    logic [ENTRY_W-1:0] raw   [3];
    logic [ENTRY_W-1:0] fwd   [3];

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = out_valid_q & out_ready;

    assign raw[0] = {in_pc, in_op1, in_op2, in_rs1, in_rs2, in_rd,
                     in_we, in_alu_ctrl, in_sub, in_sign};
    assign raw[1] = main_q;
    assign raw[2] = skid_q;

    for (genvar e = 0; e < 3; e++) begin : g_entry
`ifdef FORWARD_EN
        logic [DATA_W-1:0] op1_f;
        logic [DATA_W-1:0] op2_f;

        opd_fwd #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_op1 (
            .rs_i      (raw[e][OFF_RS1 +: ADDR_W]),
            .op_i      (raw[e][OFF_OP1 +: DATA_W]),
            .wb_we_i   (wb_we),
            .wb_addr_i (wb_addr),
            .wb_data_i (wb_data),
            .op_o      (op1_f)
        );

        opd_fwd #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_op2 (
            .rs_i      (raw[e][OFF_RS1 - ADDR_W +: ADDR_W]),
            .op_i      (raw[e][OFF_OP2 +: DATA_W]),
            .wb_we_i   (wb_we),
            .wb_addr_i (wb_addr),
            .wb_data_i (wb_data),
            .op_o      (op2_f)
        );

        assign fwd[e] = {raw[e][ENTRY_W-1 -: DATA_W], op1_f, op2_f, raw[e][OFF_RS1+ADDR_W-1:0]};
`else
        assign fwd[e] = raw[e];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ID_EX_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            state_q     <= ID_EX_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            // Held entries always take the (possibly forwarded) copy of themselves
            main_q <= fwd[1];
            skid_q <= fwd[2];
            case (state_q)
                ID_EX_EMPTY: begin
                    if (in_xfer) begin
                        main_q      <= fwd[0];
                        state_q     <= ID_EX_HALF;
                        out_valid_q <= 1'b1;
                    end
                end
                ID_EX_HALF: begin
                    if (in_xfer && out_xfer) begin
                        main_q <= fwd[0];
                    end else if (in_xfer) begin
                        skid_q     <= fwd[0];
                        state_q    <= ID_EX_FULL;
                        in_ready_q <= 1'b0;
                    end else if (out_xfer) begin
                        state_q     <= ID_EX_EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                ID_EX_FULL: begin
                    if (out_xfer) begin
                        main_q     <= fwd[2];
                        state_q    <= ID_EX_HALF;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ID_EX_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign {out_pc, out_op1, out_op2, out_rs1, out_rs2, out_rd,
            out_we, out_alu_ctrl, out_sub, out_sign} = main_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// tb/tb_id_ex_pipe.sv - randomized bench against a two-deep FIFO reference model
module tb_id_ex_pipe;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_ready, out_valid;
    logic [31:0] in_pc, in_op1, in_op2, out_pc, out_op1, out_op2;
    logic [4:0]  in_rs1, in_rs2, in_rd, out_rs1, out_rs2, out_rd;
    logic        in_we, in_sub, in_sign, out_we, out_sub, out_sign;
    logic [3:0]  in_alu_ctrl, out_alu_ctrl;
`ifdef FORWARD_EN
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
`endif

    always #5 clk = ~clk;

    id_ex_pipe dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_op1(in_op1), .in_op2(in_op2),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_we(in_we),
        .in_alu_ctrl(in_alu_ctrl), .in_sub(in_sub), .in_sign(in_sign),
        .out_ready(out_ready),
`ifdef FORWARD_EN
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
`endif
        .out_valid(out_valid),
        .out_pc(out_pc), .out_op1(out_op1), .out_op2(out_op2),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_we(out_we),
        .out_alu_ctrl(out_alu_ctrl), .out_sub(out_sub), .out_sign(out_sign)
    );

    typedef struct packed {
        logic [31:0] pc, op1, op2;
        logic [4:0]  rs1, rs2, rd;
        logic        we;
        logic [3:0]  ctrl;
        logic        sub, sign;
    } ent_t;

    ent_t mq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic ent_t fwd(input ent_t e);
`ifdef FORWARD_EN
        if (wb_we && wb_addr != 5'd0) begin
            if (e.rs1 == wb_addr) e.op1 = wb_data;
            if (e.rs2 == wb_addr) e.op2 = wb_data;
        end
`endif
        return e;
    endfunction

    // Reference: an in-order queue of at most two instructions
    always @(posedge clk) begin : model
        ent_t e;
        bit   ix, ox;
        if (rst || flush) begin
            mq.delete();
        end else begin
            ix = in_valid && (mq.size() < 2);
            ox = out_ready && (mq.size() > 0);
            foreach (mq[i]) mq[i] = fwd(mq[i]);
            if (ox) void'(mq.pop_front());
            if (ix) begin
                e.pc = in_pc;   e.op1 = in_op1; e.op2 = in_op2;
                e.rs1 = in_rs1; e.rs2 = in_rs2; e.rd = in_rd; e.we = in_we;
                e.ctrl = in_alu_ctrl; e.sub = in_sub; e.sign = in_sign;
                mq.push_back(fwd(e));
            end
        end
    end

    task automatic compare_all();
        ent_t h;
        check("out_valid", out_valid, mq.size() > 0);
        check("in_ready", in_ready, mq.size() < 2);
        if (mq.size() > 0) begin
            h = mq[0];
            check("out_pc", out_pc, h.pc);
            check("out_op1", out_op1, h.op1);
            check("out_op2", out_op2, h.op2);
            check("out_ctl", {out_rs1, out_rs2, out_rd, out_we, out_alu_ctrl, out_sub, out_sign},
                  {h.rs1, h.rs2, h.rd, h.we, h.ctrl, h.sub, h.sign});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_fields();
        in_pc       = $urandom;
        in_op1      = $urandom;
        in_op2      = $urandom;
        in_rs1      = 5'($urandom_range(7));
        in_rs2      = 5'($urandom_range(7));
        in_rd       = 5'($urandom);
        in_we       = 1'($urandom);
        in_alu_ctrl = 4'($urandom);
        in_sub      = 1'($urandom);
        in_sign     = 1'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_fields();
`ifdef FORWARD_EN
        wb_we = 1'b0; wb_addr = '0; wb_data = '0;
`endif
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [31:0] pcs[8];
    int          seen;

    initial begin
        // Reset state and single-cycle latency
        do_reset();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_op1", out_op1, 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        set_fields();
        in_valid = 1'b1; in_op1 = 32'd5;
        tick();
        check("lat_out_valid", out_valid, 1'b1);
        check("lat_out_op1", out_op1, 32'd5);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();

        // Back-to-back stream at full throughput
        seen = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) begin
                set_fields();
                in_pc = 32'h100 + 32'(4 * i);
                pcs[i] = in_pc;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            check("stream_in_ready", in_ready, 1'b1);
            if (out_valid) begin
                check("stream_order", out_pc, pcs[seen]);
                seen++;
            end
        end
        check("stream_count", seen, 8);
        tick();

        // Backpressure fills the skid; main stays stable
        out_ready = 1'b0;
        set_fields(); in_pc = 32'hA0; in_valid = 1'b1;
        tick();
        set_fields(); in_pc = 32'hB0;
        tick();
        check("bp_in_ready", in_ready, 1'b0);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_a", out_pc, 32'hA0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_then_b", out_pc, 32'hB0);
        check("bp_ready_back", in_ready, 1'b1);
        tick();
        check("bp_drained", out_valid, 1'b0);

        // Flush while full discards the concurrent capture
        out_ready = 1'b0;
        set_fields(); in_pc = 32'hA1; in_valid = 1'b1;
        tick();
        set_fields(); in_pc = 32'hB1;
        tick();
        set_fields(); in_pc = 32'hC1; flush = 1'b1;
        tick();
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_in_ready", in_ready, 1'b1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("flush_no_c", out_valid, 1'b0);
        end

`ifdef FORWARD_EN
        // Writeback patches a held operand
        out_ready = 1'b0;
        set_fields(); in_rs1 = 5'd3; in_rs2 = 5'd1; in_op1 = 32'h10; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'hAB;
        tick();
        check("fwd_held_op1", out_op1, 32'hAB);
        wb_we = 1'b0; out_ready = 1'b1;
        tick();

        // x0 never forwards; capture-cycle match takes wb_data
        out_ready = 1'b0;
        set_fields(); in_rs1 = 5'd0; in_op1 = 32'h22; in_valid = 1'b1;
        wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hFF;
        tick();
        in_valid = 1'b0;
        tick();
        check("fwd_x0_op1", out_op1, 32'h22);
        out_ready = 1'b1; wb_we = 1'b0;
        tick();
        set_fields(); in_rs2 = 5'd7; in_rs1 = 5'd2; in_op2 = 32'h5; in_valid = 1'b1;
        wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'h77;
        tick();
        check("fwd_cap_op2", out_op2, 32'h77);
        in_valid = 1'b0; wb_we = 1'b0;
        tick();
`endif

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(63) == 0);
            flush     = ($urandom_range(15) == 0);
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(3) != 0);
            set_fields();
`ifdef FORWARD_EN
            wb_we   = 1'($urandom);
            wb_addr = 5'($urandom_range(7));
            wb_data = $urandom;
`endif
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
